// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared FSM states, command field positions and default status byte
package spi_reg_pkg;
    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;
    localparam int RW_BIT = 7;
    localparam logic [7:0] STATUS_DEFAULT = 8'hA5;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchroniser with rise/fall detect against a third flop
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [2:0] s;
    // shift the asynchronous pin through sync stages and the edge register
    always_ff @(posedge clk) begin
        if (rst) s <= '0;
        else     s <= {s[1:0], din};
    end
    assign q    = s[1];
    assign rise = s[1] & ~s[2];
    assign fall = ~s[1] & s[2];
endmodule

// File: rtl/spi_reg_responder.sv
// spi_reg_responder: SPI mode-0 slave exposing a 16x8 register file with auto-increment
module spi_reg_responder
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter logic [7:0] STATUS_BYTE = STATUS_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       cs_n,
    input  logic                       mosi,
    output logic                       miso,
    output logic                       miso_oe,
    output logic                       wr_valid,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic [7:0]                 wr_data,
    output logic                       byte_done,
    output logic [8*(1<<ADDR_W)-1:0]   regs_flat
);
    localparam int NREG = 1 << ADDR_W;
    logic sclk_q, sclk_rise, sclk_fall;
    logic cs_q, cs_rise, cs_fall;
    logic mosi_q, mosi_rise, mosi_fall;
    logic unused_edges;
    state_t state;
    logic [2:0] bit_cnt;
    logic [6:0] rx_shift;
    logic [7:0] rx_byte;
    logic [7:0] tx_shift;
    logic [ADDR_W-1:0] addr;
    logic [7:0] regs [NREG];
    logic armed;
    spi_sync_edge u_sclk (.clk(clk), .rst(rst), .din(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge u_cs   (.clk(clk), .rst(rst), .din(cs_n), .q(cs_q),   .rise(cs_rise),   .fall(cs_fall));
    spi_sync_edge u_mosi (.clk(clk), .rst(rst), .din(mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall));
    assign unused_edges = ^{sclk_q, mosi_rise, mosi_fall};
    // completed byte as it would look after taking the current mosi bit
    always_comb rx_byte = {rx_shift, mosi_q};
    // frame FSM, bit counter, shifters and register file; cs_n rise always wins
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            addr      <= '0;
            regs      <= '{default: '0};
            armed     <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            byte_done <= 1'b0;
        end else begin
            wr_valid  <= 1'b0;
            byte_done <= 1'b0;
            armed     <= armed | cs_rise;
            if (cs_rise) begin
                state   <= IDLE;
                bit_cnt <= '0;
            end else if (state == IDLE) begin
                if (cs_fall && armed) begin
                    state    <= CMD;
                    tx_shift <= STATUS_BYTE;
                    bit_cnt  <= '0;
                end
            end else if (sclk_rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                rx_shift <= rx_byte[6:0];
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                    case (state)
                        CMD: begin
                            state    <= rx_byte[RW_BIT] ? RDATA : WDATA;
                            addr     <= rx_byte[RW_BIT] ? rx_byte[ADDR_W-1:0] + 1'b1 : rx_byte[ADDR_W-1:0];
                            if (rx_byte[RW_BIT]) tx_shift <= regs[rx_byte[ADDR_W-1:0]];
                        end
                        WDATA: begin
                            regs[addr] <= rx_byte;
                            wr_valid   <= 1'b1;
                            wr_addr    <= addr;
                            wr_data    <= rx_byte;
                            addr       <= addr + 1'b1;
                        end
                        default: begin
                            tx_shift <= regs[addr];
                            addr     <= addr + 1'b1;
                        end
                    endcase
                end
            end else if (sclk_fall && bit_cnt != 3'd0) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end
    assign miso    = tx_shift[7];
    assign miso_oe = ~cs_q & armed;
    for (genvar i = 0; i < NREG; i++) begin : g_flat
        assign regs_flat[8*i +: 8] = regs[i];
    end
endmodule

// File: tb/tb_spi_reg_responder.sv
// tb_spi_reg_responder: directed SPI master frames with immediate-assertion checks
module tb_spi_reg_responder;
    import spi_reg_pkg::*;
    localparam int HP = 80;
    logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic miso, miso_oe, wr_valid, byte_done;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [127:0] regs_flat;
    int n_cmp = 0, n_bad = 0, wr_cnt = 0, bd_cnt = 0;
    logic [3:0] wa_log [$];
    logic [7:0] wd_log [$];
    logic [7:0] rxb [3];
    logic oe_all;
    int wr0, bd0;
    spi_reg_responder dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .byte_done(byte_done), .regs_flat(regs_flat)
    );
    always #5 clk = ~clk;
    // log write pulses and byte completions away from the active edge
    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt <= wr_cnt + 1;
            wa_log.push_back(wr_addr);
            wd_log.push_back(wr_data);
        end
        if (byte_done) bd_cnt <= bd_cnt + 1;
    end
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] r);
        r = '0;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            #(HP);
            r = {r[6:0], miso};
            oe_all = oe_all & miso_oe;
            sclk = 1'b1;
            #(HP);
            sclk = 1'b0;
        end
    endtask
    task automatic frame_open();
        cs_n = 1'b0;
        oe_all = 1'b1;
        #(HP);
    endtask
    task automatic frame_close();
        #(HP);
        cs_n = 1'b1;
        #(2*HP);
    endtask
    task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
        logic [7:0] r;
        logic [7:0] bs [3];
        bs = '{b0, b1, b2};
        frame_open();
        for (int k = 0; k < n; k++) begin
            spi_bits(bs[k], 8, r);
            rxb[k] = r;
        end
        frame_close();
    endtask
    initial begin
        logic [7:0] r;
        #2;
        #(100);
        chk("rst_miso", miso, 0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_byte_done", byte_done, 0);
        chk("rst_regs", regs_flat, 0);
        rst = 1'b0;
        #(100);
        // single write
        wr0 = wr_cnt; bd0 = bd_cnt;
        frame(8'h03, 8'h5A, 8'h00, 2);
        chk("sw_status", rxb[0], 8'hA5);
        chk("sw_wr_cnt", wr_cnt - wr0, 1);
        chk("sw_wr_addr", wa_log[wa_log.size()-1], 3);
        chk("sw_wr_data", wd_log[wd_log.size()-1], 8'h5A);
        chk("sw_reg3", regs_flat[31:24], 8'h5A);
        chk("sw_bytes", bd_cnt - bd0, 2);
        chk("sw_oe_in", oe_all, 1);
        chk("sw_oe_out", miso_oe, 0);
        // burst write with wrap
        wr0 = wr_cnt;
        frame(8'h0F, 8'h11, 8'h22, 3);
        chk("bw_wr_cnt", wr_cnt - wr0, 2);
        chk("bw_addr0", wa_log[wr0], 15);
        chk("bw_addr1", wa_log[wr0+1], 0);
        chk("bw_data1", wd_log[wr0+1], 8'h22);
        chk("bw_reg15", regs_flat[127:120], 8'h11);
        chk("bw_reg0", regs_flat[7:0], 8'h22);
        chk("bw_reg3", regs_flat[31:24], 8'h5A);
        // read
        wr0 = wr_cnt;
        frame(8'h83, 8'h00, 8'h00, 2);
        chk("rd_status", rxb[0], 8'hA5);
        chk("rd_data", rxb[1], 8'h5A);
        chk("rd_no_wr", wr_cnt - wr0, 0);
        chk("rd_oe_in", oe_all, 1);
        chk("rd_oe_out", miso_oe, 0);
        // burst read after preload
        frame(8'h04, 8'hC3, 8'h3C, 3);
        chk("pre_reg4", regs_flat[39:32], 8'hC3);
        chk("pre_reg5", regs_flat[47:40], 8'h3C);
        wr0 = wr_cnt;
        frame(8'h84, 8'h00, 8'h00, 3);
        chk("br_status", rxb[0], 8'hA5);
        chk("br_d0", rxb[1], 8'hC3);
        chk("br_d1", rxb[2], 8'h3C);
        chk("br_no_wr", wr_cnt - wr0, 0);
        // abort mid data byte
        wr0 = wr_cnt; bd0 = bd_cnt;
        frame_open();
        spi_bits(8'h05, 8, r);
        spi_bits(8'hFF, 4, r);
        frame_close();
        chk("ab_no_wr", wr_cnt - wr0, 0);
        chk("ab_bytes", bd_cnt - bd0, 1);
        chk("ab_reg5", regs_flat[47:40], 8'h3C);
        chk("ab_idle", dut.state, IDLE);
        frame(8'h05, 8'h77, 8'h00, 2);
        chk("ab_rewrite", regs_flat[47:40], 8'h77);
        chk("ab_rewrite_addr", wa_log[wa_log.size()-1], 5);
        // reset mid-frame
        frame_open();
        spi_bits(8'h02, 8, r);
        spi_bits(8'hE7, 4, r);
        wr0 = wr_cnt;
        rst = 1'b1;
        #(30);
        rst = 1'b0;
        #(20);
        chk("mr_miso", miso, 0);
        chk("mr_oe", miso_oe, 0);
        chk("mr_wr_valid", wr_valid, 0);
        chk("mr_wr_addr", wr_addr, 0);
        chk("mr_wr_data", wr_data, 0);
        chk("mr_byte_done", byte_done, 0);
        chk("mr_regs", regs_flat, 0);
        chk("mr_idle", dut.state, IDLE);
        spi_bits(8'h70, 4, r);
        spi_bits(8'hAB, 8, r);
        frame_close();
        chk("mr_no_wr", wr_cnt - wr0, 0);
        chk("mr_regs_after", regs_flat, 0);
        frame(8'h02, 8'h99, 8'h00, 2);
        chk("mr_next_status", rxb[0], 8'hA5);
        chk("mr_next_reg2", regs_flat[23:16], 8'h99);
        chk("mr_next_addr", wa_log[wa_log.size()-1], 2);
        chk("mr_next_cnt", wr_cnt - wr0, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
